// File: rtl/cv32e40s_pkg.sv
// Shared types and helpers for the bit-select ("k-th set bit") unit.
package cv32e40s_pkg;

  typedef enum logic [1:0] {
    BS_IDLE,
    BS_SCAN,
    BS_DONE
  } bitsel_state_e;

  localparam int unsigned BS_WORD_W = 32;
  localparam int unsigned BS_POS_W  = 5;

  // Chunk widths must divide the word evenly and be powers of two.
  function automatic logic bs_chunk_w_legal(input int unsigned w);
    return (w == 4) || (w == 8) || (w == 16) || (w == 32);
  endfunction

endpackage

// File: rtl/cv32e40s_bitselect_chunk.sv
// Combinational per-chunk select: popcount, hit flag and offset of the rank-th set bit.
module cv32e40s_bitselect_chunk
  import cv32e40s_pkg::*;
#(
  parameter int unsigned W = 8,
  localparam int unsigned CNT_W = $clog2(W) + 1,
  localparam int unsigned OFF_W = $clog2(W)
) (
  input  logic [W-1:0]          chunk,
  input  logic [BS_POS_W-1:0]   rank,
  output logic [CNT_W-1:0]      cnt,
  output logic                  hit,
  output logic [OFF_W-1:0]      offset
);

  // Six bits hold a running count of up to 32 set bits.
  logic [5:0] seen;

  always_comb begin
    seen   = '0;
    offset = '0;
    for (int i = 0; i < W; i++) begin
      if (chunk[i]) begin
        if (seen == {1'b0, rank}) begin
          offset = i[OFF_W-1:0];
        end
        seen = seen + 6'd1;
      end
    end
    cnt = seen[CNT_W-1:0];
    hit = ({1'b0, rank} < seen);
  end

endmodule

// File: rtl/cv32e40s_bitselect.sv
// Multi-cycle select unit: locates the rank-th set bit of a 32-bit word, CHUNK_W bits per cycle.
module cv32e40s_bitselect
  import cv32e40s_pkg::*;
#(
  parameter int unsigned CHUNK_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [BS_WORD_W-1:0]  word_i,
  input  logic [BS_POS_W-1:0]   rank_i,
  input  logic                  kill_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [BS_POS_W-1:0]   pos_o,
  output logic                  found_o
);

  localparam int unsigned NCHUNK = BS_WORD_W / CHUNK_W;
  localparam int unsigned CIDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned NSLOT  = 1 << CIDX_W;
  localparam int unsigned CNT_W  = $clog2(CHUNK_W) + 1;
  localparam int unsigned OFF_W  = $clog2(CHUNK_W);

  if (!bs_chunk_w_legal(CHUNK_W)) begin : g_bad_chunk_w
    $error("cv32e40s_bitselect: CHUNK_W must be 4, 8, 16 or 32");
  end

  bitsel_state_e          state_reg, state_next;
  logic [BS_WORD_W-1:0]   word_reg, word_next;
  logic [BS_POS_W-1:0]    rem_reg, rem_next;
  logic [CIDX_W-1:0]      c_reg, c_next;
  logic [BS_POS_W-1:0]    pos_reg, pos_next;
  logic                   found_reg, found_next;

  // Slot array is padded to a power of two so c_reg can never index past it.
  logic [CHUNK_W-1:0]     chunks [NSLOT];
  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
    if (gi < NCHUNK) begin : g_real
      assign chunks[gi] = word_reg[gi*CHUNK_W +: CHUNK_W];
    end else begin : g_pad
      assign chunks[gi] = '0;
    end
  end

  logic [CHUNK_W-1:0]     chunk_cur;
  logic [CNT_W-1:0]       cnt;
  logic                   hit;
  logic [OFF_W-1:0]       offset;
  logic [BS_POS_W-1:0]    pos_hit;
  logic                   last_chunk;

  assign chunk_cur  = chunks[c_reg];
  assign last_chunk = (c_reg == CIDX_W'(NCHUNK - 1));
  assign pos_hit    = BS_POS_W'((32'(c_reg) << OFF_W) | 32'(offset));

  cv32e40s_bitselect_chunk #(
    .W (CHUNK_W)
  ) chunk_sel (
    .chunk  (chunk_cur),
    .rank   (rem_reg),
    .cnt    (cnt),
    .hit    (hit),
    .offset (offset)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= BS_IDLE;
      word_reg  <= '0;
      rem_reg   <= '0;
      c_reg     <= '0;
      pos_reg   <= '0;
      found_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      word_reg  <= word_next;
      rem_reg   <= rem_next;
      c_reg     <= c_next;
      pos_reg   <= pos_next;
      found_reg <= found_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    word_next  = word_reg;
    rem_next   = rem_reg;
    c_next     = c_reg;
    pos_next   = pos_reg;
    found_next = found_reg;
    unique case (state_reg)
      BS_IDLE: begin
        if (valid_i) begin
          word_next  = word_i;
          rem_next   = rank_i;
          c_next     = '0;
          state_next = BS_SCAN;
        end
      end
      BS_SCAN: begin
        if (kill_i) begin
          state_next = BS_IDLE;
        end else if (hit) begin
          pos_next   = pos_hit;
          found_next = 1'b1;
          state_next = BS_DONE;
        end else if (last_chunk) begin
          pos_next   = '0;
          found_next = 1'b0;
          state_next = BS_DONE;
        end else begin
          // cnt <= rem here, so the subtraction cannot wrap.
          rem_next = rem_reg - BS_POS_W'(cnt);
          c_next   = c_reg + CIDX_W'(1);
        end
      end
      BS_DONE: begin
        if (kill_i || ready_i) begin
          state_next = BS_IDLE;
        end
      end
      default: state_next = BS_IDLE;
    endcase
  end

  assign ready_o = (state_reg == BS_IDLE);
  assign valid_o = (state_reg == BS_DONE);
  assign pos_o   = pos_reg;
  assign found_o = found_reg;

endmodule

// File: tb/tb_cv32e40s_bitselect.sv
// Self-checking bench: four instances (CHUNK_W = 4, 8, 16, 32) share stimulus; instance 1 is CHUNK_W=8.
module tb_cv32e40s_bitselect;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, kill_i, ready_i;
  logic [31:0] word_i;
  logic [4:0]  rank_i;

  logic        ready_o_a [4];
  logic        valid_o_a [4];
  logic        found_o_a [4];
  logic [4:0]  pos_o_a   [4];

  int compared   = 0;
  int mismatched = 0;

  int          res_lat   [4];
  logic [4:0]  res_pos   [4];
  logic        res_found [4];
  bit          res_ready_low;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    cv32e40s_bitselect #(.CHUNK_W(4 << gi)) dut (
      .clk     (clk),
      .rst     (rst),
      .valid_i (valid_i),
      .ready_o (ready_o_a[gi]),
      .word_i  (word_i),
      .rank_i  (rank_i),
      .kill_i  (kill_i),
      .valid_o (valid_o_a[gi]),
      .ready_i (ready_i),
      .pos_o   (pos_o_a[gi]),
      .found_o (found_o_a[gi])
    );
  end

  // Reference: walk the word from the LSB counting set bits; latency from the chunk holding the hit.
  function automatic void ref_select(input logic [31:0] w, input int rank, input int cw,
                                     output logic found, output int pos, output int lat);
    int seen = 0;
    found = 1'b0;
    pos   = 0;
    for (int b = 0; b < 32; b++) begin
      if (w[b]) begin
        if (seen == rank && !found) begin
          found = 1'b1;
          pos   = b;
        end
        seen++;
      end
    end
    lat = found ? (pos / cw) + 2 : (32 / cw) + 1;
  endfunction

  // Issue one operand and record, per instance, the edge after which valid_o first appears.
  task automatic run_op(input logic [31:0] w, input logic [4:0] r);
    bit seen_v [4];
    bit all_seen;
    for (int i = 0; i < 4; i++) begin
      seen_v[i] = 1'b0; res_lat[i] = 0; res_pos[i] = '0; res_found[i] = 1'b0;
    end
    res_ready_low = 1'b1;
    @(negedge clk);
    valid_i = 1'b1; word_i = w; rank_i = r;
    @(negedge clk);
    valid_i = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      all_seen = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (!seen_v[i]) begin
          if (i == 1 && ready_o_a[1] !== 1'b0) res_ready_low = 1'b0;
          if (valid_o_a[i] === 1'b1) begin
            seen_v[i]    = 1'b1;
            res_lat[i]   = e;
            res_pos[i]   = pos_o_a[i];
            res_found[i] = found_o_a[i];
          end else begin
            all_seen = 1'b0;
          end
        end
      end
      if (all_seen) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (ready_o_a[i] !== 1'b1 || valid_o_a[i] !== 1'b0 || pos_o_a[i] !== 5'd0 || found_o_a[i] !== 1'b0) begin
        mismatched++;
        $display("FAIL reset[%0d]: got ready=%b valid=%b pos=%0d found=%b, expected 1 0 0 0",
                 i, ready_o_a[i], valid_o_a[i], pos_o_a[i], found_o_a[i]);
      end
    end
    $display("reset check done");
  endtask

  task automatic test_basic();
    run_op(32'h0000_0001, 5'd0);
    $display("op word=00000001 rank=0 pos=%0d found=%0d lat=%0d", res_pos[1], res_found[1], res_lat[1]);
    compared++;
    if (res_found[1] !== 1'b1 || res_pos[1] !== 5'd0 || res_lat[1] != 2) begin
      mismatched++;
      $display("FAIL basic_lsb: got found=%b pos=%0d lat=%0d, expected 1 0 2", res_found[1], res_pos[1], res_lat[1]);
    end
    compared++;
    if (!res_ready_low) begin
      mismatched++;
      $display("FAIL basic_ready: got ready_o high during scan, expected low");
    end
    run_op(32'h8000_0000, 5'd0);
    $display("op word=80000000 rank=0 pos=%0d found=%0d lat=%0d", res_pos[1], res_found[1], res_lat[1]);
    compared++;
    if (res_found[1] !== 1'b1 || res_pos[1] !== 5'd31 || res_lat[1] != 5) begin
      mismatched++;
      $display("FAIL basic_msb: got found=%b pos=%0d lat=%0d, expected 1 31 5", res_found[1], res_pos[1], res_lat[1]);
    end
  endtask

  task automatic test_hold();
    ready_i = 1'b0;
    run_op(32'h1248_0000, 5'd2);
    $display("op word=12480000 rank=2 pos=%0d found=%0d lat=%0d", res_pos[1], res_found[1], res_lat[1]);
    compared++;
    if (res_found[1] !== 1'b1 || res_pos[1] !== 5'd25 || res_lat[1] != 5) begin
      mismatched++;
      $display("FAIL hold_result: got found=%b pos=%0d lat=%0d, expected 1 25 5", res_found[1], res_pos[1], res_lat[1]);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      compared++;
      if (valid_o_a[1] !== 1'b1 || ready_o_a[1] !== 1'b0 || pos_o_a[1] !== 5'd25 || found_o_a[1] !== 1'b1) begin
        mismatched++;
        $display("FAIL hold_stable[%0d]: got valid=%b ready=%b pos=%0d found=%b, expected 1 0 25 1",
                 k, valid_o_a[1], ready_o_a[1], pos_o_a[1], found_o_a[1]);
      end
    end
    ready_i = 1'b1;
    @(negedge clk);
    compared++;
    if (valid_o_a[1] !== 1'b0 || ready_o_a[1] !== 1'b1) begin
      mismatched++;
      $display("FAIL hold_release: got valid=%b ready=%b, expected 0 1", valid_o_a[1], ready_o_a[1]);
    end
  endtask

  task automatic test_not_found();
    run_op(32'hFFFF_FFFF, 5'd31);
    $display("op word=ffffffff rank=31 pos=%0d found=%0d lat=%0d", res_pos[1], res_found[1], res_lat[1]);
    compared++;
    if (res_found[1] !== 1'b1 || res_pos[1] !== 5'd31 || res_lat[1] != 5) begin
      mismatched++;
      $display("FAIL all_ones: got found=%b pos=%0d lat=%0d, expected 1 31 5", res_found[1], res_pos[1], res_lat[1]);
    end
    run_op(32'h0000_00F0, 5'd4);
    $display("op word=000000f0 rank=4 pos=%0d found=%0d lat=%0d", res_pos[1], res_found[1], res_lat[1]);
    compared++;
    if (res_found[1] !== 1'b0 || res_pos[1] !== 5'd0 || res_lat[1] != 5) begin
      mismatched++;
      $display("FAIL rank_too_big: got found=%b pos=%0d lat=%0d, expected 0 0 5", res_found[1], res_pos[1], res_lat[1]);
    end
    run_op(32'h0000_0000, 5'd0);
    $display("op word=00000000 rank=0 pos=%0d found=%0d lat=%0d", res_pos[1], res_found[1], res_lat[1]);
    compared++;
    if (res_found[1] !== 1'b0 || res_pos[1] !== 5'd0 || res_lat[1] != 5) begin
      mismatched++;
      $display("FAIL zero_word: got found=%b pos=%0d lat=%0d, expected 0 0 5", res_found[1], res_pos[1], res_lat[1]);
    end
  endtask

  task automatic test_kill_reset();
    bit saw_valid;
    ready_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b1; word_i = 32'h8000_0000; rank_i = 5'd0;
    @(negedge clk);                       // after acceptance edge
    valid_i = 1'b0;
    @(negedge clk);                       // second SCAN cycle
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (ready_o_a[i] !== 1'b1 || valid_o_a[i] !== 1'b0) begin
        mismatched++;
        $display("FAIL kill_idle[%0d]: got ready=%b valid=%b, expected 1 0", i, ready_o_a[i], valid_o_a[i]);
      end
    end
    saw_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (valid_o_a[1] !== 1'b0) saw_valid = 1'b1;
    end
    compared++;
    if (saw_valid) begin
      mismatched++;
      $display("FAIL kill_discard: got valid_o=1 after kill, expected 0");
    end
    $display("op kill word=80000000 rank=0 done");

    @(negedge clk);
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);                       // CHUNK_W=32 instance now holds pos 31
    compared++;
    if (valid_o_a[3] !== 1'b1 || pos_o_a[3] !== 5'd31) begin
      mismatched++;
      $display("FAIL pre_reset_w32: got valid=%b pos=%0d, expected 1 31", valid_o_a[3], pos_o_a[3]);
    end
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (ready_o_a[i] !== 1'b1 || valid_o_a[i] !== 1'b0 || pos_o_a[i] !== 5'd0 || found_o_a[i] !== 1'b0) begin
        mismatched++;
        $display("FAIL async_reset[%0d]: got ready=%b valid=%b pos=%0d found=%b, expected 1 0 0 0",
                 i, ready_o_a[i], valid_o_a[i], pos_o_a[i], found_o_a[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    $display("op async reset mid-scan done");
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [4:0]  r;
    int          pc, ep, el;
    logic        ef;
    ready_i = 1'b1;
    for (int n = 0; n < 60; n++) begin
      w = $urandom;
      case ($urandom_range(0, 3))
        0: w = w & $urandom & $urandom;
        1: w = 32'h1 << $urandom_range(0, 31);
        2: if ($urandom_range(0, 3) == 0) w = 32'h0;
        default: ;
      endcase
      pc = $countones(w);
      if (pc == 0 || $urandom_range(0, 3) == 0) r = 5'($urandom);
      else r = 5'($urandom_range(0, pc - 1));
      run_op(w, r);
      for (int i = 0; i < 4; i++) begin
        ref_select(w, int'(r), 4 << i, ef, ep, el);
        compared++;
        if (res_found[i] !== ef || res_pos[i] !== 5'(ep) || res_lat[i] != el) begin
          mismatched++;
          $display("FAIL random[%0d] cw=%0d word=%h rank=%0d: got found=%b pos=%0d lat=%0d, expected %b %0d %0d",
                   n, 4 << i, w, r, res_found[i], res_pos[i], res_lat[i], ef, ep, el);
        end
      end
      $display("op %0d word=%h rank=%0d pos=%0d found=%0d", n, w, r, res_pos[1], res_found[1]);
    end
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b1;
    word_i = '0; rank_i = '0;
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_basic();
    test_hold();
    test_not_found();
    test_kill_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
